// File: rtl/ec_flags_pkg.sv
// Shared types and constants for the error-correction flag poller.
// Holds the poll FSM encoding and the flag PIO register map.
package ec_flags_pkg;

    localparam int unsigned FLAG_W_DEF = 3;

    // Byte offset of the data register inside the flag PIO
    localparam logic [31:0] PIO_DATA_OFS = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE
    } state_t;

endpackage

// File: rtl/ec_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count holds at all-ones.
module ec_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc until all-ones, zero on reset or clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ec_flags_poller.sv
// Avalon-MM read master that polls the flag PIO on a fixed period,
// accumulating sticky flags, an error-poll count and a level irq.
module ec_flags_poller
    import ec_flags_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FLAG_W      = FLAG_W_DEF,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [FLAG_W-1:0] last_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    output logic [CNT_W-1:0]  err_count,
    output logic              irq,
    output logic              timeout_err,
    output logic              poll_done
);

    localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [15:0]   PER_LAST = 16'(POLL_PERIOD - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    logic [15:0]       timer;
    logic [TO_W-1:0]   to_cnt;
    logic [FLAG_W-1:0] captured;
    logic              cnt_inc;
    logic              unused_rd;

    // Upper read-data bits carry nothing for this block
    assign unused_rd = ^avm_readdata[31:FLAG_W];

    // Address never changes, so it is stable through any stall
    assign avm_address = BASE_ADDR + PIO_DATA_OFS;

    assign cnt_inc = (state == S_UPDATE) && (captured != '0);

    ec_sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (cnt_inc),
        .count (err_count)
    );

    // Poll FSM with period/timeout timers and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            to_cnt       <= '0;
            captured     <= '0;
            avm_read     <= 1'b0;
            last_flags   <= '0;
            sticky_flags <= '0;
            timeout_err  <= 1'b0;
            poll_done    <= 1'b0;
            irq          <= 1'b0;
        end else begin
            poll_done <= 1'b0;
            irq       <= clear ? 1'b0 : ((|sticky_flags) | timeout_err);

            unique case (state)
                S_IDLE: begin
                    if (!enable) begin
                        timer <= '0;
                    end else if (timer == PER_LAST) begin
                        timer    <= '0;
                        avm_read <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        to_cnt   <= '0;
                        // Zero-latency fabrics return data with the accept
                        if (avm_readdatavalid) begin
                            captured <= avm_readdata[FLAG_W-1:0];
                            state    <= S_UPDATE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (avm_readdatavalid) begin
                        captured <= avm_readdata[FLAG_W-1:0];
                        state    <= S_UPDATE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        poll_done   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    last_flags   <= captured;
                    sticky_flags <= sticky_flags | captured;
                    poll_done    <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    avm_read <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase

            // Clear overrides anything accumulated this cycle
            if (clear) begin
                sticky_flags <= '0;
                timeout_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ec_flags_poller.sv
// Directed bench for ec_flags_poller: table of polls plus
// hand sequences for interval, enable, clear-in-update and reset.
module tb_ec_flags_poller;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [2:0]  last_flags;
    logic [2:0]  sticky_flags;
    logic [1:0]  err_count;
    logic        irq;
    logic        timeout_err;
    logic        poll_done;

    ec_flags_poller #(
        .POLL_PERIOD (4),
        .BASE_ADDR   (BASE),
        .FLAG_W      (3),
        .CNT_W       (2),
        .TIMEOUT     (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .clear             (clear),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .last_flags        (last_flags),
        .sticky_flags      (sticky_flags),
        .err_count         (err_count),
        .irq               (irq),
        .timeout_err       (timeout_err),
        .poll_done         (poll_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // fabric model configuration and state
    int         stall_cfg = 0;
    bit         drop_cfg  = 0;
    bit         zl_cfg    = 0;
    logic [2:0] data_cfg  = 3'd0;
    bit         inject    = 0;
    bit         in_req    = 0;
    int         stall_left = 0;
    bit         pending   = 0;
    logic [2:0] pend_data = 3'd0;
    int         n_acc     = 0;
    int         acc_edge  = 0;
    int         rd_len    = 0;
    int         addr_bad  = 0;

    typedef struct {
        int         stall;
        bit         drop;
        bit         zl;
        bit         clr;
        logic [2:0] data;
        int         lat;
        logic [2:0] e_last;
        logic [2:0] e_sticky;
        logic [1:0] e_cnt;
        bit         e_terr;
        bit         e_irq0;
        bit         e_irq1;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // one clock: advance to the falling edge, then run the fabric model
    task automatic tick();
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        if (pending) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = {29'd0, pend_data};
            pending           = 1'b0;
        end
        if (inject) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'h7;
            inject            = 1'b0;
        end
        if (avm_read) begin
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = stall_cfg;
                rd_len     = 0;
            end
            rd_len++;
            if (avm_address !== BASE) addr_bad++;
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
                in_req   = 1'b0;
                n_acc++;
                acc_edge = cyc + 1;
                if (zl_cfg) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = {29'd0, data_cfg};
                end else if (!drop_cfg) begin
                    pending   = 1'b1;
                    pend_data = data_cfg;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (poll_done) begin
                found = 1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_read(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (avm_read) begin
                found = 1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    initial begin
        int acc0;
        int e1;
        int rst_edge;
        int a1;
        reset             = 1'b1;
        enable            = 1'b1;
        clear             = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'd0;
        avm_readdatavalid = 1'b0;

        //              stl drp zl clr dat lat last  stk   cnt t  i0 i1
        vt[0]  = '{0, 0, 0, 0, 3'd0, 2, 3'd0, 3'd0, 2'd0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 3'd5, 2, 3'd5, 3'd5, 2'd1, 0, 0, 1};
        vt[2]  = '{5, 0, 0, 0, 3'd2, 2, 3'd2, 3'd7, 2'd2, 0, 1, 1};
        vt[3]  = '{0, 1, 0, 0, 3'd0, 8, 3'd2, 3'd7, 2'd2, 1, 1, 1};
        vt[4]  = '{0, 0, 0, 1, 3'd1, 2, 3'd1, 3'd1, 2'd1, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 0, 3'd1, 2, 3'd1, 3'd1, 2'd2, 0, 1, 1};
        vt[6]  = '{0, 0, 0, 0, 3'd1, 2, 3'd1, 3'd1, 2'd3, 0, 1, 1};
        vt[7]  = '{0, 0, 0, 0, 3'd1, 2, 3'd1, 3'd1, 2'd3, 0, 1, 1};
        vt[8]  = '{0, 0, 0, 0, 3'd1, 2, 3'd1, 3'd1, 2'd3, 0, 1, 1};
        vt[9]  = '{0, 0, 1, 0, 3'd4, 1, 3'd4, 3'd5, 2'd3, 0, 1, 1};
        vt[10] = '{0, 0, 0, 1, 3'd0, 2, 3'd0, 3'd0, 2'd0, 0, 0, 0};

        for (int i = 0; i < 3; i++) tick();
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, BASE);
        chk("rst_last", 32'(last_flags), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_cnt", 32'(err_count), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_done", 32'(poll_done), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            stall_cfg = vt[v].stall;
            drop_cfg  = vt[v].drop;
            zl_cfg    = vt[v].zl;
            data_cfg  = vt[v].data;
            if (vt[v].clr) begin
                clear = 1'b1;
                tick();
                clear = 1'b0;
            end
            acc0 = n_acc;
            wait_done($sformatf("v%0d_done", v));
            chk($sformatf("v%0d_last", v), 32'(last_flags),
                32'(vt[v].e_last));
            chk($sformatf("v%0d_sticky", v), 32'(sticky_flags),
                32'(vt[v].e_sticky));
            chk($sformatf("v%0d_cnt", v), 32'(err_count),
                32'(vt[v].e_cnt));
            chk($sformatf("v%0d_terr", v), 32'(timeout_err),
                32'(vt[v].e_terr));
            chk($sformatf("v%0d_irq0", v), 32'(irq), 32'(vt[v].e_irq0));
            chk($sformatf("v%0d_lat", v), 32'(cyc - acc_edge),
                32'(vt[v].lat));
            chk($sformatf("v%0d_rdlen", v), 32'(rd_len),
                32'(vt[v].stall + 1));
            chk($sformatf("v%0d_nacc", v), 32'(n_acc - acc0), 32'd1);
            chk($sformatf("v%0d_addr", v), 32'(addr_bad), 32'd0);
            tick();
            chk($sformatf("v%0d_irq1", v), 32'(irq), 32'(vt[v].e_irq1));
            chk($sformatf("v%0d_done1", v), 32'(poll_done), 32'd0);
        end

        // back-to-back interval, no stalls, latency 1
        stall_cfg = 0;
        drop_cfg  = 0;
        zl_cfg    = 0;
        data_cfg  = 3'd0;
        wait_done("iv_done_a");
        e1 = acc_edge;
        wait_done("iv_done_b");
        chk("iv_period", 32'(acc_edge - e1), 32'd7);

        // enable low: no new requests once idle
        enable = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        a1 = n_acc;
        for (int i = 0; i < 15; i++) tick();
        chk("en_nacc", 32'(n_acc - a1), 32'd0);
        chk("en_read", 32'(avm_read), 32'd0);
        data_cfg = 3'd1;
        enable   = 1'b1;
        wait_done("en_done");
        chk("en_last", 32'(last_flags), 32'd1);
        chk("en_sticky", 32'(sticky_flags), 32'd1);
        chk("en_cnt", 32'(err_count), 32'd1);

        // clear in the UPDATE cycle
        data_cfg = 3'd2;
        wait_read("cu_read");
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("cu_done", 32'(poll_done), 32'd1);
        chk("cu_last", 32'(last_flags), 32'd2);
        chk("cu_sticky", 32'(sticky_flags), 32'd0);
        chk("cu_cnt", 32'(err_count), 32'd0);
        tick();
        chk("cu_irq", 32'(irq), 32'd0);

        // reset in WAIT, then a late readdatavalid
        drop_cfg = 1;
        wait_read("rw_read");
        tick();
        reset    = 1'b1;
        rst_edge = cyc + 1;
        tick();
        chk("rw_read_drop", 32'(avm_read), 32'd0);
        reset    = 1'b0;
        drop_cfg = 0;
        data_cfg = 3'd0;
        in_req   = 0;
        pending  = 0;
        inject   = 1;
        tick();
        chk("rw_last", 32'(last_flags), 32'd0);
        chk("rw_sticky", 32'(sticky_flags), 32'd0);
        chk("rw_cnt", 32'(err_count), 32'd0);
        chk("rw_irq", 32'(irq), 32'd0);
        wait_read("rw_next_read");
        chk("rw_next_at", 32'(cyc - rst_edge), 32'd4);
        chk("rw_last2", 32'(last_flags), 32'd0);
        wait_done("rw_done");
        chk("rw_last3", 32'(last_flags), 32'd0);
        chk("rw_sticky3", 32'(sticky_flags), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ec_flags_poller.md
Name: ec_flags_poller

Overview:
- Avalon-MM read master that periodically polls the 3-bit error-correction flag input PIO at a fixed word address.
- Accumulates sticky flag bits and a saturating count of polls that returned non-zero flags, and raises a level interrupt.
- Gives arithmetic datapath monitoring logic (or a host-independent watchdog) flag status without Nios software polling the PIO.
- Sits on the q_sys fabric as a master, beside the CPU data master.

Parameters:
- POLL_PERIOD, 1024: clocks between the end of one poll and the start of the next; legal range 2..65535.
- BASE_ADDR, 32'h0000_0000: byte address of the flag PIO data register (offset 0).
- FLAG_W, 3: number of flag bits taken from readdata[FLAG_W-1:0].
- CNT_W, 16: width of the error-poll counter.
- TIMEOUT, 255: maximum clocks to wait for readdatavalid after the request is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = polling runs; 0 = finish any outstanding transaction, then idle.
- clear  in  1  single-cycle pulse; clears sticky_flags, err_count, irq and timeout_err.
- avm_address  out  32  byte address; always BASE_ADDR.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  fabric stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- last_flags  out  FLAG_W  flags from the most recent completed poll.
- sticky_flags  out  FLAG_W  OR of all flags since the last clear.
- err_count  out  CNT_W  number of polls with non-zero flags; saturates at all-ones.
- irq  out  1  level; set when any sticky flag is set or timeout_err is set.
- timeout_err  out  1  sticky; a read timed out.
- poll_done  out  1  one-cycle pulse each time a poll completes or times out.

Behaviour:
- Reset: all outputs 0 except avm_address = BASE_ADDR. FSM goes to IDLE and the period timer loads 0.
- FSM states:
  - IDLE: counts the timer up to POLL_PERIOD-1. On reaching it with enable=1, go to REQ and clear the timer. If enable=0, hold the timer at 0.
  - REQ: avm_read=1. Stay while avm_waitrequest=1. On the cycle avm_waitrequest=0, go to WAIT and clear the timeout counter. avm_read must stay high and avm_address stable for the whole stall (Avalon rule). This state is not abortable by enable.
  - WAIT: avm_read=0 and the timeout counter increments. On avm_readdatavalid=1, capture readdata[FLAG_W-1:0] and go to UPDATE. If the counter reaches TIMEOUT with no valid, set timeout_err, pulse poll_done and go to IDLE; last_flags is unchanged.
  - UPDATE (1 cycle):
    - last_flags <= captured value.
    - sticky_flags <= sticky_flags | captured.
    - If captured != 0 and err_count != all-ones, err_count increments.
    - Pulse poll_done, then go to IDLE.
- readdatavalid arriving in the same cycle that waitrequest drops (zero-latency fabric) is also accepted. REQ then goes straight to UPDATE.
- readdatavalid seen in IDLE or REQ (stray) is ignored.
- clear coinciding with UPDATE: clear wins for sticky_flags and err_count, but last_flags still updates. The captured flags are therefore lost from the accumulators.
- clear coinciding with a timeout: timeout_err ends 0.
- irq = |sticky_flags | timeout_err, registered, so it lags its sources by 1 cycle.
- Poll interval, request accept to request accept with no stalls and read latency 1: POLL_PERIOD + 3 clocks (IDLE count + REQ + WAIT + UPDATE).
- Reset asserted mid-transaction drops avm_read the next cycle. Any late readdatavalid after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package ec_flags_pkg:
  - FSM state enum (IDLE, REQ, WAIT, UPDATE).
  - FLAG_W default.
  - PIO data-register offset constant (0).
- One sub-module: ec_sat_counter (CNT_W-wide saturating incrementer with synchronous clear). It is reused for err_count.
- The period and timeout timers are inline.

Test Plan:
- POLL_PERIOD=4, zero-wait fabric with latency 1, readdata=0: poll_done every 7 clocks; err_count stays 0; irq=0.
- readdata=32'h5 on the second poll: last_flags=3'b101, sticky=3'b101, err_count=1, and irq rises 1 clock after poll_done.
- waitrequest held high 5 cycles: avm_read stays high with a stable address for 6 cycles, and exactly one transaction is issued.
- readdatavalid withheld and TIMEOUT=8: timeout_err=1 8 clocks after accept, poll_done pulses, last_flags unchanged, next poll proceeds.
- CNT_W=2 with 5 consecutive polls of flags=3'b001: err_count saturates at 3.
- clear asserted in the UPDATE cycle with flags=3'b010: sticky=0 and err_count=0, last_flags=3'b010.
- reset mid-WAIT followed by a late readdatavalid: the flag outputs (last_flags, sticky_flags, err_count) stay 0, and the next poll occurs POLL_PERIOD after reset release.
